// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect request and the
// valid/ready instruction stream toward decode.
interface fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a combinational
// instruction memory into a 2-entry FIFO, handles redirect and halt/run.
module fetch_sequencer #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int              PC_STEP  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       halt,
    fetch_if.master    bus,
    output logic [1:0] state,
    output logic       misalign
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [DATA_W-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic              pop_s, push_s, space_s;

    // Next-state, PC and buffer update; redirect overrides halt and push/pop.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        misalign_d   = misalign_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        push_s       = 1'b0;
        pop_s        = valid_q && bus.out_ready && !bus.redirect_valid;
        space_s      = (count_q < 2'd2) || pop_s;

        if (bus.redirect_valid) begin
            count_d    = 2'd0;
            pc_d       = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
            misalign_d = misalign_q | bus.redirect_pc[0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) state_d = ST_FETCH;
                    else     state_d = ST_IDLE;
                end
                ST_FETCH: begin
                    if (halt) state_d = ST_HALTED;
                    else      push_s  = space_s;
                end
                ST_HALTED: begin
                    if (run && !halt) state_d = ST_FETCH;
                    else              state_d = ST_HALTED;
                end
                default: state_d = ST_IDLE;
            endcase

            if (push_s) pc_d = pc_q + STEP;
            else        pc_d = pc_q;

            // A simultaneous pop shifts the tail up before the new entry lands.
            case ({pop_s, push_s})
                2'b10: begin
                    head_pc_d    = tail_pc_q;
                    head_instr_d = tail_instr_q;
                    count_d      = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        head_pc_d    = pc_q;
                        head_instr_d = bus.mem_data;
                    end else begin
                        tail_pc_d    = pc_q;
                        tail_instr_d = bus.mem_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        tail_pc_d    = pc_q;
                        tail_instr_d = bus.mem_data;
                    end else begin
                        head_pc_d    = pc_q;
                        head_instr_d = bus.mem_data;
                    end
                end
                default: count_d = count_q;
            endcase
        end

        valid_d = (count_d != 2'd0);
    end

    // State, PC and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            count_q      <= 2'd0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign bus.mem_addr  = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.out_pc    = head_pc_q;
    assign bus.out_instr = head_instr_q;
    assign state         = state_q;
    assign misalign      = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level model predicts
// fetched {pc, instr} pairs; a negedge monitor compares them as decode consumes.
module tb_fetch_sequencer;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       run   = 1'b0;
    logic       halt  = 1'b0;
    logic [1:0] state;
    logic       misalign;

    fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(16'h0000), .PC_STEP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt),
        .bus(bus), .state(state), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Memory image: word i holds A000+i.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + {1'b0, a[15:1]};
    endfunction

    assign bus.mem_data = mem_word(bus.mem_addr);

    typedef struct {
        int pc;
        int instr;
    } item_t;

    item_t exp_q[$];
    int    m_mode = 0;   // 0 idle, 1 fetching, 2 halted
    int    m_pc   = 0;
    int    m_cnt  = 0;
    bit    m_mis  = 1'b0;
    bit    m_pop, m_push;
    item_t m_item;

    int checks = 0;
    int passed = 0;
    int delivered = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: updates on each clock edge or on reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_pc = 0; m_cnt = 0; m_mis = 1'b0;
                exp_q.delete();
            end else if (bus.redirect_valid) begin
                exp_q.delete();
                m_cnt = 0;
                m_pc  = int'(bus.redirect_pc) & 32'hFFFE;
                if (bus.redirect_pc[0]) m_mis = 1'b1;
            end else begin
                m_pop  = (m_cnt > 0) && bus.out_ready;
                m_push = 1'b0;
                case (m_mode)
                    0: if (run) m_mode = 1;
                    1: if (halt) m_mode = 2; else m_push = (m_cnt - int'(m_pop)) < 2;
                    2: if (run && !halt) m_mode = 1;
                    default: m_mode = 0;
                endcase
                if (m_pop) m_cnt--;
                if (m_push) begin
                    m_item.pc    = m_pc;
                    m_item.instr = int'(mem_word(16'(m_pc)));
                    exp_q.push_back(m_item);
                    m_cnt++;
                    m_pc = (m_pc + 2) % 65536;
                end
            end
        end
    end

    // Monitor: compare outputs at the falling edge and retire accepted heads.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("out_valid", int'(bus.out_valid), int'(m_cnt != 0));
                check("mem_addr", int'(bus.mem_addr), m_pc);
                check("state", int'(state), m_mode);
                check("misalign", int'(misalign), int'(m_mis));
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_empty: DUT presents pc %h with nothing expected", bus.out_pc);
                    end else begin
                        check("out_pc", int'(bus.out_pc), exp_q[0].pc);
                        check("out_instr", int'(bus.out_instr), exp_q[0].instr);
                        if (bus.out_ready && !bus.redirect_valid) begin
                            void'(exp_q.pop_front());
                            delivered++;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redir(input logic [15:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        cyc(1);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.out_ready      = 1'b0;
        cyc(2);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_pc", int'(bus.out_pc), 0);
        check("rst_out_instr", int'(bus.out_instr), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_state", int'(state), 0);
        rst_n = 1'b1;

        // start-up and streaming
        run = 1'b1; bus.out_ready = 1'b1;
        cyc(8);
        // backpressure from a fresh PC
        bus.out_ready = 1'b0; redir(16'h0000);
        cyc(5);
        bus.out_ready = 1'b1;
        cyc(4);
        // redirect with full buffer and ready high, then misaligned target
        bus.out_ready = 1'b0; cyc(3);
        bus.out_ready = 1'b1; redir(16'h0040);
        cyc(3);
        redir(16'h0041);
        cyc(3);
        // halt, load PC near the top, resume across the wrap
        halt = 1'b1; run = 1'b0; cyc(4);
        redir(16'hFFFC);
        halt = 1'b0; run = 1'b1;
        cyc(6);
        // halt with one buffered entry
        bus.out_ready = 1'b0; redir(16'h0100);
        cyc(1);
        halt = 1'b1; cyc(2);
        bus.out_ready = 1'b1; cyc(3);
        halt = 1'b0; cyc(4);
        // redirect and halt together
        halt = 1'b1; redir(16'h0200);
        halt = 1'b0; cyc(3);

        // asynchronous reset between edges
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(bus.out_valid), 0);
        check("arst_mem_addr", int'(bus.mem_addr), 0);
        check("arst_state", int'(state), 0);
        check("arst_misalign", int'(misalign), 0);
        check("arst_out_pc", int'(bus.out_pc), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b0;
        cyc(3);
        run = 1'b1;
        cyc(4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            run                = ($urandom % 8) != 0;
            halt               = ($urandom % 6) == 0;
            bus.out_ready      = ($urandom % 3) != 0;
            bus.redirect_valid = ($urandom % 16) == 0;
            bus.redirect_pc    = 16'($urandom);
            cyc(1);
        end
        bus.redirect_valid = 1'b0;
        cyc(2);

        check("delivered_enough", int'(delivered >= 50), 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
